// File: rtl/alu_seq_n.sv
// Registered WIDTH-bit ALU with valid/ready handshake, flags, accumulator feedback and
// bit-serial shifts. Define ALU_MUL_EN to add an iterative shift-add multiply on opcode 1010.
module alu_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic             ALU_clk,
  input  logic             ALU_reset,
  input  logic             ALU_in_valid,
  output logic             ALU_in_ready,
  input  logic [3:0]       ALU_option,
  input  logic             ALU_acc_sel,
  input  logic [WIDTH-1:0] ALU_in1,
  input  logic [WIDTH-1:0] ALU_in2,
  output logic             ALU_out_valid,
  input  logic             ALU_out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             ALU_Cout,
  output logic             ALU_zero,
  output logic             ALU_neg,
  output logic             ALU_ovf,
  output logic             ALU_err,
  output logic             ALU_busy
);

  // state | meaning
  // IDLE  | no result held, ready for a request
  // BUSY  | iterating a shift (or multiply) one step per clock
  // DONE  | result presented, waiting for consumer

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic [WIDTH-1:0] opnd_a, opnd_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w;

  logic [WIDTH-1:0] s_res;
  logic             s_cout, s_ovf, s_err, s_iter;

  logic [WIDTH-1:0] step_work;
  logic             step_cout;

  logic [WIDTH-1:0] fin_res;
  logic             fin_cout, fin_ovf, fin_err, done_now;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mul_hi, step_hi;
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, mul_hi} + (work[0] ? {1'b0, mcand} : '0);
`endif

  assign ALU_in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && ALU_out_ready);
  assign ALU_out_valid = (state == ST_DONE);
  assign ALU_busy      = (state == ST_BUSY);
  assign accept        = ALU_in_valid && ALU_in_ready;

  // acc already holds a result being handed off this cycle, so chaining needs no bypass
  assign opnd_a = ALU_acc_sel ? acc : ALU_in1;
  assign opnd_b = ALU_in2;
  assign shamt  = ALU_in2[SHW-1:0];
  assign add_w  = {1'b0, opnd_a} + {1'b0, opnd_b};
  assign sub_w  = {1'b0, opnd_a} - {1'b0, opnd_b};

  always_comb begin
    s_res  = '0;
    s_cout = 1'b0;
    s_ovf  = 1'b0;
    s_err  = 1'b0;
    s_iter = 1'b0;
    case (ALU_option)
      OP_ADD: begin
        {s_cout, s_res} = add_w;
        s_ovf = (opnd_a[WIDTH-1] == opnd_b[WIDTH-1]) && (add_w[WIDTH-1] != opnd_a[WIDTH-1]);
      end
      OP_SUB: begin
        {s_cout, s_res} = sub_w;
        s_ovf = (opnd_a[WIDTH-1] != opnd_b[WIDTH-1]) && (sub_w[WIDTH-1] != opnd_a[WIDTH-1]);
      end
      OP_AND: s_res = opnd_a & opnd_b;
      OP_OR:  s_res = opnd_a | opnd_b;
      OP_NOT: s_res = ~opnd_a;
      OP_XOR: s_res = opnd_a ^ opnd_b;
      OP_NEG: s_res = '0 - opnd_a;
      OP_SHL, OP_SHR, OP_SRA: begin
        s_res  = opnd_a;
        s_iter = (shamt != '0);
      end
`ifdef ALU_MUL_EN
      OP_MUL: s_iter = 1'b1;
`endif
      default: s_err = 1'b1;
    endcase
  end

  always_comb begin
    step_work = work;
    step_cout = 1'b0;
`ifdef ALU_MUL_EN
    step_hi = mul_hi;
`endif
    case (op_q)
      OP_SHL: begin
        step_work = {work[WIDTH-2:0], 1'b0};
        step_cout = work[WIDTH-1];
      end
      OP_SHR: begin
        step_work = {1'b0, work[WIDTH-1:1]};
        step_cout = work[0];
      end
      OP_SRA: begin
        step_work = {work[WIDTH-1], work[WIDTH-1:1]};
        step_cout = work[0];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        step_work = {mul_sum[0], work[WIDTH-1:1]};
        step_hi   = mul_sum[WIDTH:1];
        step_cout = |mul_sum[WIDTH:1];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    if (state == ST_BUSY) begin
      fin_res  = step_work;
      fin_cout = step_cout;
      fin_ovf  = 1'b0;
      fin_err  = 1'b0;
      done_now = (cnt == CW'(1));
    end else begin
      fin_res  = s_res;
      fin_cout = s_cout;
      fin_ovf  = s_ovf;
      fin_err  = s_err;
      done_now = accept && !s_iter;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)
          state_nxt = s_iter ? ST_BUSY : ST_DONE;
        else if ((state == ST_DONE) && ALU_out_ready)
          state_nxt = ST_IDLE;
      end
      ST_BUSY: if (cnt == CW'(1)) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ALU_clk or posedge ALU_reset) begin
    if (ALU_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      work     <= '0;
      acc      <= '0;
      ALU_out  <= '0;
      ALU_Cout <= 1'b0;
      ALU_zero <= 1'b0;
      ALU_neg  <= 1'b0;
      ALU_ovf  <= 1'b0;
      ALU_err  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand    <= '0;
      mul_hi   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= ALU_option;
        work <= opnd_a;
        cnt  <= {1'b0, shamt};
`ifdef ALU_MUL_EN
        if (ALU_option == OP_MUL) begin
          work   <= opnd_b;
          mcand  <= opnd_a;
          mul_hi <= '0;
          cnt    <= CW'(WIDTH);
        end
`endif
      end else if (state == ST_BUSY) begin
        work <= step_work;
        cnt  <= cnt - CW'(1);
`ifdef ALU_MUL_EN
        mul_hi <= step_hi;
`endif
      end
      if (done_now) begin
        ALU_out  <= fin_res;
        acc      <= fin_res;
        ALU_Cout <= fin_cout;
        ALU_zero <= (fin_res == '0) && !fin_err;
        ALU_neg  <= fin_res[WIDTH-1];
        ALU_ovf  <= fin_ovf;
        ALU_err  <= fin_err;
      end
    end
  end

endmodule
